reset_sequencer: RTL



---
 rtl/reset_seq_pkg.sv | 19 +
 rtl/reset_sequencer_if.sv | 22 ++
 rtl/reset_sync.sv | 21 ++
 rtl/reset_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and limits for the reset sequencer.
// State encoding, synchroniser depth and legal parameter ranges.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  localparam int SYNC_DEPTH = 2;

  localparam int NUM_OUT_MIN      = 1;
  localparam int NUM_OUT_MAX      = 16;
  localparam int STAGE_CYCLES_MIN = 1;
  localparam int STAGE_CYCLES_MAX = 65535;

endpackage

// File: rtl/reset_sequencer_if.sv
// Status/request bundle between the reset sequencer and its consumers.
// The SW_REQ signal exists only when RESET_SEQ_SWREQ_EN is defined.
interface reset_sequencer_if #(
  parameter int NUM_OUT = 4
);

`ifdef RESET_SEQ_SWREQ_EN
  logic               SW_REQ;
`endif
  logic [NUM_OUT-1:0] RST_OUT_N;
  logic               READY;
  logic               BUSY;

`ifdef RESET_SEQ_SWREQ_EN
  modport master (input SW_REQ, output RST_OUT_N, output READY, output BUSY);
  modport slave  (output SW_REQ, input RST_OUT_N, input READY, input BUSY);
`else
  modport master (output RST_OUT_N, output READY, output BUSY);
  modport slave  (input RST_OUT_N, input READY, input BUSY);
`endif

endinterface

// File: rtl/reset_sync.sv
// Reset synchroniser: asserts asynchronously with RST, releases after
// SYNC_DEPTH clock edges.
module reset_sync
  import reset_seq_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  output logic sync_rst
);

  logic [SYNC_DEPTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b0};
  end

  assign sync_rst = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Fans RST out into NUM_OUT active-low resets released in index order,
// STAGE_CYCLES apart. RESET_SEQ_SWREQ_EN adds a software re-run request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT      = 4,
  parameter int STAGE_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RST,
  reset_sequencer_if.master  seq_if
);

  localparam int CNT_W = $clog2(STAGE_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

  if (NUM_OUT < NUM_OUT_MIN || NUM_OUT > NUM_OUT_MAX) begin : g_bad_num_out
    $error("reset_sequencer: NUM_OUT out of range");
  end
  if (STAGE_CYCLES < STAGE_CYCLES_MIN || STAGE_CYCLES > STAGE_CYCLES_MAX) begin : g_bad_stage
    $error("reset_sequencer: STAGE_CYCLES out of range");
  end

  logic               sync_rst;
  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_n_q, rst_out_n_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               release_now;
  logic               clear_outs;

  reset_sync u_reset_sync (
    .CLK      (CLK),
    .RST      (RST),
    .sync_rst (sync_rst)
  );

  // NOTE: every register, outputs included, clears asynchronously so RST reaches the tree with no clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_n_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_out_n_q <= rst_out_n_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: defaults first in every combinational block keep it latch-free.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    release_now = 1'b0;
    clear_outs  = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        if (!sync_rst) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_HOLD, ST_RELEASE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          release_now = 1'b1;
          idx_d       = idx_q + IDX_W'(1);
          state_d     = (idx_q == IDX_LAST) ? ST_DONE : ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
`ifdef RESET_SEQ_SWREQ_EN
        if (seq_if.SW_REQ) begin
          state_d    = ST_HOLD;
          cnt_d      = '0;
          idx_d      = '0;
          clear_outs = 1'b1;
        end
`endif
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  always_comb begin
    rst_out_n_d = clear_outs ? '0 : rst_out_n_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (release_now && idx_q == IDX_W'(i)) rst_out_n_d[i] = 1'b1;
    end
    ready_d = (state_d == ST_DONE);
    busy_d  = !ready_d;
  end

  assign seq_if.RST_OUT_N = rst_out_n_q;
  assign seq_if.READY     = ready_q;
  assign seq_if.BUSY      = busy_q;

endmodule
